route_sequencer: RTL and testbench



---
 rtl/route_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_route_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/route_sequencer.sv
// Route sequencer for semi-auto driving mode.
// Stores a programmed list of crossroad decisions and replays one per
// crossroad stop onto the semi-auto FSM direction inputs. While a route is
// running it owns those inputs; otherwise the manual buttons pass through.
module route_sequencer #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 250
) (
    input  logic              clk_20ms,
    input  logic              rst,
    input  logic              power,
    input  logic [1:0]        global_state,
    input  logic [1:0]        nav_state,
    input  logic              prog_en,
    input  logic              prog_valid,
    input  logic [1:0]        prog_cmd,
    input  logic              run_en,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_straight,
    input  logic              btn_back,
    output logic              left,
    output logic              right,
    output logic              straight,
    output logic              back,
    output logic [ADDR_W:0]   route_len,
    output logic [ADDR_W:0]   route_idx,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [1:0] GS_SEMI = 2'b10;
    localparam logic [1:0] NAV_FWD = 2'b01;
    localparam logic [1:0] NAV_WAIT = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE, S_PROG, S_WAIT_XR, S_ISSUE, S_ACK, S_DONE, S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Direction vector bit order: {back, right, left, straight}
    logic [3:0]        dir_q, dir_d;
    logic              busy_q, busy_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic              prog_valid_q, run_en_q;
    logic              wr_en;
    logic              prog_edge, run_edge, abort;

    logic [1:0]        mem [DEPTH];

    // Decode a stored route entry into a one-hot direction vector.
    function automatic logic [3:0] decode_cmd(input logic [1:0] cmd);
        case (cmd)
            2'b00:   decode_cmd = 4'b0001;
            2'b01:   decode_cmd = 4'b0010;
            2'b10:   decode_cmd = 4'b0100;
            default: decode_cmd = 4'b1000;
        endcase
    endfunction

    assign prog_edge = prog_valid & ~prog_valid_q;
    assign run_edge  = run_en & ~run_en_q;
    assign abort     = ~power | (global_state != GS_SEMI) | ~run_en;

    // Next-state, counters and next direction outputs.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dir_d   = 4'b0000;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prog_en) begin
                    state_d = S_PROG;
                    len_d   = '0;
                end else if (run_edge && len_q != '0 && power && global_state == GS_SEMI) begin
                    state_d = S_WAIT_XR;
                    idx_d   = '0;
                end else begin
                    dir_d = {btn_back, btn_right, btn_left, btn_straight};
                end
            end
            S_PROG: begin
                // A write coinciding with prog_en falling still lands.
                if (prog_edge && len_q != LEN_MAX) begin
                    wr_en = 1'b1;
                    len_d = len_q + 1'b1;
                end
                if (!prog_en) state_d = S_IDLE;
            end
            S_WAIT_XR: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (nav_state == NAV_WAIT) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (nav_state != NAV_WAIT) begin
                    state_d = S_ACK;
                    idx_d   = idx_q + 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    dir_d = decode_cmd(mem[idx_q[ADDR_W-1:0]]);
                end
            end
            S_ACK: begin
                // Wait for cruising again so the same stop is not served twice.
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (nav_state == NAV_FWD) begin
                    state_d = (idx_q == len_q) ? S_DONE : S_WAIT_XR;
                end
            end
            S_DONE, S_FAULT: begin
                if (!run_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d == S_WAIT_XR) || (state_d == S_ISSUE) || (state_d == S_ACK);
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
        full_d  = (len_d == LEN_MAX);
    end

    // Register FSM state, counters, edge detectors and all outputs.
    always_ff @(posedge clk_20ms) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            dir_q        <= 4'b0000;
            busy_q       <= 1'b0;
            full_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            prog_valid_q <= 1'b0;
            run_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            full_q       <= full_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            prog_valid_q <= prog_valid;
            run_en_q     <= run_en;
        end
    end

    // Route storage; deliberately not reset so contents survive rst.
    always_ff @(posedge clk_20ms) begin
        if (wr_en) mem[len_q[ADDR_W-1:0]] <= prog_cmd;
    end

    assign straight  = dir_q[0];
    assign left      = dir_q[1];
    assign right     = dir_q[2];
    assign back      = dir_q[3];
    assign route_len = len_q;
    assign route_idx = idx_q;
    assign busy      = busy_q;
    assign full      = full_q;
    assign done      = done_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_route_sequencer.sv
// Scoreboard bench for route_sequencer: the driver pushes expected output
// snapshots tagged with the cycle they apply to; a negedge monitor pops and
// compares them independently of the stimulus.
module tb_route_sequencer;

    logic       clk_20ms = 1'b0;
    logic       rst = 1'b1;
    logic       power = 1'b0;
    logic [1:0] global_state = 2'b00;
    logic [1:0] nav_state = 2'b01;
    logic       prog_en = 1'b0;
    logic       prog_valid = 1'b0;
    logic [1:0] prog_cmd = 2'b00;
    logic       run_en = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_straight = 1'b0, btn_back = 1'b0;
    logic       left, right, straight, back;
    logic [3:0] route_len, route_idx;
    logic       busy, full, done, fault;

    route_sequencer #(.DEPTH(8), .ADDR_W(3), .TIMEOUT(250)) dut (
        .clk_20ms(clk_20ms), .rst(rst), .power(power), .global_state(global_state),
        .nav_state(nav_state), .prog_en(prog_en), .prog_valid(prog_valid),
        .prog_cmd(prog_cmd), .run_en(run_en), .btn_left(btn_left),
        .btn_right(btn_right), .btn_straight(btn_straight), .btn_back(btn_back),
        .left(left), .right(right), .straight(straight), .back(back),
        .route_len(route_len), .route_idx(route_idx), .busy(busy), .full(full),
        .done(done), .fault(fault)
    );

    always #5 clk_20ms = ~clk_20ms;

    localparam logic [3:0] D_NONE = 4'b0000;
    localparam logic [3:0] D_STR  = 4'b0001;
    localparam logic [3:0] D_LEFT = 4'b0010;
    localparam logic [3:0] D_RGT  = 4'b0100;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        end_req = 1'b0;
    int          due_q[$];
    string       name_q[$];
    logic [15:0] exp_q[$];

    always @(posedge clk_20ms) cyc <= cyc + 1;

    // Observed snapshot: {back,right,left,straight, len, idx, busy, full, done, fault}
    function automatic logic [15:0] observe();
        return {back, right, left, straight, route_len, route_idx, busy, full, done, fault};
    endfunction

    task automatic tick();
        @(posedge clk_20ms);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [3:0] d, input int len,
                              input int idx, input logic b, input logic f,
                              input logic dn, input logic ft);
        logic [3:0] l4, i4;
        l4 = len[3:0];
        i4 = idx[3:0];
        due_q.push_back(cyc);
        name_q.push_back(nm);
        exp_q.push_back({d, l4, i4, b, f, dn, ft});
    endtask

    // Monitor: compare every snapshot that falls due, then close the run.
    always @(negedge clk_20ms) begin
        logic [15:0] got, want;
        string nm;
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            nm = name_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (due_q.pop_front() != cyc) begin
                failures++;
                $display("FAIL %s stale entry at cycle %0d", nm, cyc);
            end else begin
                got = observe();
                if (got !== want) begin
                    failures++;
                    $display("FAIL %s got dir=%b len=%0d idx=%0d bfdf=%b want dir=%b len=%0d idx=%0d bfdf=%b",
                             nm, got[15:12], got[11:8], got[7:4], got[3:0],
                             want[15:12], want[11:8], want[7:4], want[3:0]);
                end
            end
        end
        if (end_req) begin
            checks++;
            if (due_q.size() != 0) begin
                failures++;
                $display("FAIL drain got=%0d pending want=0", due_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
        if (cyc > 5000) begin
            $display("FAIL watchdog got cycle=%0d want <=5000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    // Walk through one crossroad: stop, issue, accept, cooldown, cruise.
    task automatic crossroad(input string nm, input logic [3:0] d, input int idx_after,
                             input int len, input logic last);
        nav_state = 2'b00; tick();
        expect_out({nm, "_issue_enter"}, D_NONE, len, idx_after - 1, 1, 0, 0, 0);
        tick();
        expect_out({nm, "_cmd"}, d, len, idx_after - 1, 1, 0, 0, 0);
        nav_state = 2'b10; tick();
        expect_out({nm, "_accept"}, D_NONE, len, idx_after, 1, 0, 0, 0);
        nav_state = 2'b11; tick();
        expect_out({nm, "_cooldown"}, D_NONE, len, idx_after, 1, 0, 0, 0);
        nav_state = 2'b01; tick();
        expect_out({nm, "_cruise"}, D_NONE, len, idx_after, !last, 0, last, 0);
    endtask

    initial begin
        // Reset with buttons pressed: outputs must stay cleared.
        btn_left = 1'b1;
        tick(); tick();
        expect_out("reset", D_NONE, 0, 0, 0, 0, 0, 0);
        btn_left = 1'b0;
        rst = 1'b0;
        power = 1'b1;
        global_state = 2'b10;

        // Run request with an empty route is ignored.
        run_en = 1'b1; tick();
        expect_out("run_empty", D_NONE, 0, 0, 0, 0, 0, 0);
        run_en = 1'b0; tick();

        // Program left, right, straight; last write coincides with prog_en falling.
        prog_en = 1'b1; tick();
        expect_out("prog_enter", D_NONE, 0, 0, 0, 0, 0, 0);
        prog_cmd = 2'b01; prog_valid = 1'b1; tick();
        expect_out("prog_1", D_NONE, 1, 0, 0, 0, 0, 0);
        tick();
        expect_out("prog_level_no_write", D_NONE, 1, 0, 0, 0, 0, 0);
        prog_valid = 1'b0; tick();
        prog_cmd = 2'b10; prog_valid = 1'b1; tick();
        expect_out("prog_2", D_NONE, 2, 0, 0, 0, 0, 0);
        prog_valid = 1'b0; tick();
        prog_cmd = 2'b00; prog_valid = 1'b1; prog_en = 1'b0; tick();
        expect_out("prog_3_exit", D_NONE, 3, 0, 0, 0, 0, 0);
        prog_valid = 1'b0;
        btn_right = 1'b1; tick();
        expect_out("idle_btn_right", D_RGT, 3, 0, 0, 0, 0, 0);
        btn_right = 1'b0; tick();

        // Run the 3-entry route.
        nav_state = 2'b01; run_en = 1'b1; tick();
        expect_out("run_start", D_NONE, 3, 0, 1, 0, 0, 0);
        btn_left = 1'b1;
        crossroad("xr1", D_LEFT, 1, 3, 1'b0);
        btn_left = 1'b0;
        crossroad("xr2", D_RGT, 2, 3, 1'b0);
        crossroad("xr3", D_STR, 3, 3, 1'b1);
        run_en = 1'b0; tick();
        expect_out("done_exit", D_NONE, 3, 3, 0, 0, 0, 0);

        // Acceptance timeout: command held 250 ticks, then fault.
        run_en = 1'b1; tick();
        expect_out("to_start", D_NONE, 3, 0, 1, 0, 0, 0);
        nav_state = 2'b00; tick();
        expect_out("to_issue", D_NONE, 3, 0, 1, 0, 0, 0);
        tick();
        expect_out("to_cmd_first", D_LEFT, 3, 0, 1, 0, 0, 0);
        for (int k = 2; k <= 250; k++) begin
            tick();
            if (k == 125 || k == 250) expect_out("to_cmd_held", D_LEFT, 3, 0, 1, 0, 0, 0);
        end
        tick();
        expect_out("to_fault", D_NONE, 3, 0, 0, 0, 0, 1);
        tick();
        expect_out("to_fault_hold", D_NONE, 3, 0, 0, 0, 0, 1);
        run_en = 1'b0; nav_state = 2'b01; tick();
        expect_out("fault_exit", D_NONE, 3, 0, 0, 0, 0, 0);

        // Abort from ACK via global_state, then manual pass-through.
        run_en = 1'b1; tick();
        nav_state = 2'b00; tick();
        tick();
        expect_out("ab_cmd", D_LEFT, 3, 0, 1, 0, 0, 0);
        nav_state = 2'b10; tick();
        expect_out("ab_ack", D_NONE, 3, 1, 1, 0, 0, 0);
        global_state = 2'b01; tick();
        expect_out("ab_idle", D_NONE, 3, 0, 0, 0, 0, 0);
        btn_left = 1'b1; tick();
        expect_out("ab_btn_left", D_LEFT, 3, 0, 0, 0, 0, 0);
        btn_left = 1'b0; global_state = 2'b10; run_en = 1'b0; nav_state = 2'b01; tick();
        expect_out("ab_btn_release", D_NONE, 3, 0, 0, 0, 0, 0);

        // Reset in the middle of ISSUE.
        run_en = 1'b1; tick();
        nav_state = 2'b00; tick();
        tick();
        expect_out("rst_cmd", D_LEFT, 3, 0, 1, 0, 0, 0);
        rst = 1'b1; tick();
        expect_out("rst_mid", D_NONE, 0, 0, 0, 0, 0, 0);
        rst = 1'b0; run_en = 1'b0; nav_state = 2'b01; tick();

        // Fill to DEPTH and push two extra entries.
        prog_en = 1'b1; tick();
        for (int k = 1; k <= 10; k++) begin
            prog_cmd = 2'b11; prog_valid = 1'b1; tick();
            expect_out("fill", D_NONE, (k > 8) ? 8 : k, 0, 0, k >= 8, 0, 0);
            prog_valid = 1'b0; tick();
        end
        prog_en = 1'b0; tick();
        expect_out("fill_exit", D_NONE, 8, 0, 0, 1, 0, 0);

        tick();
        end_req = 1'b1;
    end

endmodule
